mem_burst_ctrl: RTL and testbench
=================================

// Module: mem_burst_ctrl
// PURPOSE
//  Burst sequencer upstream of the single-port synchronous RAM (write when en=1, combinational read when en=0).
//  Accepts one burst command at a time (start address, length, direction).
//  Write bursts: moves a valid/ready write stream into consecutive RAM words.
//  Read bursts: streams consecutive RAM words out on a registered valid/ready read port.
// PARAMETERS
//  ADDR_WIDTH  4   RAM address width; must match the RAM instance
//  DATA_WIDTH  32  RAM word width; must match the RAM instance
//  LEN_WIDTH   4   burst length field width; burst = cmd_len+1 beats (1..2**LEN_WIDTH)
// PORTS
//  clk        in   1           single clock, all logic on rising edge
//  rst        in   1           reset, synchronous, active-low
//  cmd_valid  in   1           command present
//  cmd_ready  out  1           command accepted when valid&&ready
//  cmd_write  in   1           1=write burst, 0=read burst
//  cmd_addr   in   ADDR_WIDTH  start address
//  cmd_len    in   LEN_WIDTH   beats minus one
//  wr_valid   in   1           write beat present
//  wr_ready   out  1           write beat accepted when valid&&ready
//  wr_data    in   DATA_WIDTH  write beat data
//  rd_valid   out  1           read beat present (registered)
//  rd_ready   in   1           downstream accepts read beat
//  rd_data    out  DATA_WIDTH  read beat data (registered)
//  rd_last    out  1           marks final beat of read burst
//  busy       out  1           state != IDLE
//  mem_en     out  1           to RAM en (1=write)
//  mem_addr   out  ADDR_WIDTH  to RAM address
//  mem_wdata  out  DATA_WIDTH  to RAM data_in
//  mem_rdata  in   DATA_WIDTH  from RAM data_out
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-low.
//  Reset (rst=0 at clk edge): state=IDLE; cmd_ready=0 during reset; wr_ready=0, rd_valid=0, rd_data=0, rd_last=0,
//   busy=0, mem_en=0, mem_addr=0. Reset mid-burst aborts it; remaining beats are dropped. No RAM write occurs in a reset cycle.
//  States: IDLE, WRITE, READ, DRAIN.
//  IDLE: cmd_ready=1. On cmd handshake, latch addr_q=cmd_addr, cnt_q=cmd_len, go WRITE (cmd_write=1) or READ.
//  WRITE: wr_ready=1; mem_en=wr_valid (combinational); mem_addr=addr_q; mem_wdata=wr_data.
//   Each handshake: addr_q+=1, cnt_q-=1. On the handshake with cnt_q==0, go IDLE.
//   No handshake means no mem_en and no change to addr_q or cnt_q.
//  READ: mem_en=0; mem_addr=addr_q. Beat capture when !rd_valid || rd_ready:
//   rd_data<=mem_rdata, rd_valid<=1, rd_last<=(cnt_q==0), addr_q+=1, cnt_q-=1. After the capture with cnt_q==0, go DRAIN.
//   Latency: address-to-rd_valid is 1 cycle. Full throughput is 1 beat/cycle while rd_ready=1.
//  DRAIN: hold the last beat. On rd_valid&&rd_ready: rd_valid<=0, rd_last<=0, go IDLE.
//  Outside READ/DRAIN, rd_valid=0. rd_data is held stable while rd_valid&&!rd_ready.
//  Address arithmetic is modulo 2**ADDR_WIDTH: 0xF+1 wraps to 0x0 for ADDR_WIDTH=4.
//  cmd_ready=0 outside IDLE. A new command is not accepted in the cycle its predecessor completes.
//  IDLE drives mem_en=0 and mem_addr=addr_q.
// CONFIGURATION
//  MEM_BURST_BOUNDARY_CHECK_EN defined: cmd_addr+cmd_len > 2**ADDR_WIDTH-1 is a boundary error.
//   Such a command is still handshaken, but the block stays IDLE.
//   Extra output port err (1 bit, reset 0) pulses high for exactly 1 cycle after the handshake.
//   No RAM access takes place.
//  Not defined: no err port; bursts wrap modulo 2**ADDR_WIDTH as above.
// TESTING
//  1. Write addr=2 len=3, data A0..A3 with wr_valid=1 continuously -> mem_en high 4 cycles, addr 2,3,4,5; RAM[2..5]=A0..A3; IDLE after 4th beat.
//  2. Read addr=2 len=3, rd_ready=1 -> rd_valid 4 consecutive cycles starting 1 cycle after entering READ;
//     rd_data=A0..A3; rd_last only on A3.
//  3. Read len=3 with rd_ready toggling 1,0,0,1,... -> no lost or duplicated beat; rd_data stable while stalled; mem_en stays 0.
//  4. Write addr=0xE len=2 (no macro) -> RAM[0xE],[0xF],[0x0] written. With MEM_BURST_BOUNDARY_CHECK_EN -> err pulse 1 cycle, no mem_en, busy stays 0.
//  5. rst=0 during 2nd beat of a write with len=5 -> next cycle IDLE, wr_ready=0, rd_valid=0.
//     Later beats do not reach RAM; earlier beats are retained by this block's reset (RAM reset is separate).
//  6. Write with wr_valid gaps (1,0,1,0,1, len=2) -> mem_en exactly on the valid cycles; addresses contiguous.

Source files
------------

// File: rtl/mem_burst_ctrl_if.sv
// mem_burst_ctrl_if
//  Handshake bundle between a burst master and mem_burst_ctrl.
//  cmd_* : one burst command (start address, beats minus one, direction)
//  wr_*  : write data stream, valid/ready
//  rd_*  : read data stream, valid/ready, rd_last marks the final beat
//  Modports: master drives commands, write beats and rd_ready;
//            slave is the controller side.
interface mem_burst_ctrl_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;

  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;

  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_last;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output wr_valid, wr_data,
    output rd_ready,
    input  cmd_ready, wr_ready,
    input  rd_valid, rd_data, rd_last
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  wr_valid, wr_data,
    input  rd_ready,
    output cmd_ready, wr_ready,
    output rd_valid, rd_data, rd_last
  );
endinterface

// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl
//  Burst sequencer in front of a single-port synchronous RAM
//  (RAM writes when en=1, reads combinationally when en=0).
//  One command at a time; write bursts move the wr stream into consecutive
//  RAM words, read bursts stream consecutive words out on a registered port.
// Ports
//  clk       : single clock, rising edge
//  rst       : synchronous, active-low reset
//  bus       : mem_burst_ctrl_if.slave (cmd_*, wr_*, rd_* handshakes)
//  busy      : controller is not IDLE
//  mem_en    : RAM write enable
//  mem_addr  : RAM address
//  mem_wdata : RAM write data
//  mem_rdata : RAM read data (combinational from mem_addr)
//  err       : only with MEM_BURST_BOUNDARY_CHECK_EN; one-cycle pulse after a
//              command whose burst would run past the top address
// Configuration macro: MEM_BURST_BOUNDARY_CHECK_EN
//  undefined : bursts wrap modulo 2**ADDR_WIDTH
//  defined   : out-of-range commands are accepted but ignored, err pulses
module mem_burst_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_burst_ctrl_if.slave       bus,
  output logic                  busy,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
`ifdef MEM_BURST_BOUNDARY_CHECK_EN
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  err
`else
  input  logic [DATA_WIDTH-1:0] mem_rdata
`endif
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  cnt_q;
  logic                  rd_valid_q;
  logic                  rd_last_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  cmd_hs;
  logic                  wr_hs;
  logic                  bound_err;

  // Ready signals are gated with rst so that nothing handshakes, and no RAM
  // write is issued, in a cycle where reset is being applied.
  assign bus.cmd_ready = rst && (state == IDLE);
  assign bus.wr_ready  = rst && (state == WRITE);
  assign cmd_hs        = bus.cmd_valid && bus.cmd_ready;
  assign wr_hs         = bus.wr_valid && bus.wr_ready;

  assign mem_en    = wr_hs;
  assign mem_addr  = addr_q;
  assign mem_wdata = bus.wr_data;
  assign busy      = (state != IDLE);

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_last  = rd_last_q;
  assign bus.rd_data  = rd_data_q;

`ifdef MEM_BURST_BOUNDARY_CHECK_EN
  localparam int SW = ((ADDR_WIDTH > LEN_WIDTH) ? ADDR_WIDTH : LEN_WIDTH) + 1;
  logic [SW-1:0] end_addr;
  logic          err_q;

  // The last address of the burst is computed one bit wider than either
  // field so an overrun past the top of the RAM is visible instead of wrapping.
  always_comb begin
    end_addr  = SW'(bus.cmd_addr) + SW'(bus.cmd_len);
    bound_err = (end_addr > SW'((1 << ADDR_WIDTH) - 1));
  end

  assign err = err_q;

  // err is a registered one-cycle pulse following the rejected handshake.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= cmd_hs && bound_err;
    end
  end
`else
  assign bound_err = 1'b0;
`endif

  // Main sequencer. addr_q and cnt_q advance once per accepted beat; the
  // read side captures a fresh RAM word whenever the output register is empty
  // or being consumed, which gives one beat per cycle while rd_ready stays high.
  // The final read beat is held in DRAIN until the consumer takes it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_hs && !bound_err) begin
            addr_q <= bus.cmd_addr;
            cnt_q  <= bus.cmd_len;
            state  <= bus.cmd_write ? WRITE : READ;
          end
        end
        WRITE: begin
          if (wr_hs) begin
            addr_q <= addr_q + 1'b1;
            cnt_q  <= cnt_q - 1'b1;
            if (cnt_q == '0) state <= IDLE;
          end
        end
        READ: begin
          if (!rd_valid_q || bus.rd_ready) begin
            rd_data_q  <= mem_rdata;
            rd_valid_q <= 1'b1;
            rd_last_q  <= (cnt_q == '0);
            addr_q     <= addr_q + 1'b1;
            cnt_q      <= cnt_q - 1'b1;
            if (cnt_q == '0) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (rd_valid_q && bus.rd_ready) begin
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb_mem_burst_ctrl
//  Directed bench for mem_burst_ctrl. A behavioural RAM sits on the mem_*
//  port; expected RAM writes and expected read beats are queued when the
//  stimulus is issued and popped by a monitor when the DUT produces them.
module tb_mem_burst_ctrl;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int LW = 4;

  logic          clk;
  logic          rst;
  logic          busy;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef MEM_BURST_BOUNDARY_CHECK_EN
  logic          err;
`endif

  mem_burst_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  mem_burst_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .busy      (busy),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
`ifdef MEM_BURST_BOUNDARY_CHECK_EN
    .mem_rdata (mem_rdata),
    .err       (err)
`else
    .mem_rdata (mem_rdata)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0]    ram     [16];
  logic [DW-1:0]    exp_mem [16];
  logic [AW+DW-1:0] wq[$];
  logic [DW:0]      rq[$];

  logic          prev_stall;
  logic [DW-1:0] prev_data;

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM: synchronous write, combinational read
  always @(posedge clk) if (mem_en === 1'b1) ram[mem_addr] <= mem_wdata;
  assign mem_rdata = ram[mem_addr];

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor on the falling edge: every RAM write and every consumed read beat
  // must match the head of its queue; a stalled read beat must not change.
  always @(negedge clk) begin
    if (mem_en === 1'b1) begin
      check_output("wr_pending", 64'(wq.size() > 0), 64'd1);
      if (wq.size() > 0) check_output("wr_beat", 64'({mem_addr, mem_wdata}), 64'(wq.pop_front()));
    end
    if (prev_stall === 1'b1) begin
      check_output("rd_stall_valid", 64'(bus.rd_valid), 64'd1);
      check_output("rd_stall_data", 64'(bus.rd_data), 64'(prev_data));
    end
    if (bus.rd_valid === 1'b1 && bus.rd_ready === 1'b1) begin
      check_output("rd_pending", 64'(rq.size() > 0), 64'd1);
      if (rq.size() > 0) check_output("rd_beat", 64'({bus.rd_last, bus.rd_data}), 64'(rq.pop_front()));
    end
    prev_stall = (bus.rd_valid === 1'b1) && (bus.rd_ready === 1'b0);
    prev_data  = bus.rd_data;
  end

  // Present a command and wait (bounded) for the handshake edge.
  task automatic apply_stimulus(input logic wr, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    int guard = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    while (bus.cmd_ready !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    check_output("cmd_ready_wait", 64'(bus.cmd_ready), 64'd1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // Drive write beats following a valid pattern; expected writes are queued.
  task automatic write_beats(input logic [AW-1:0] start, input logic [15:0] pattern,
                             input int n, input logic [DW-1:0] base);
    logic [AW-1:0] a = start;
    for (int i = 0; i < n; i++) begin
      bus.wr_valid = pattern[i];
      bus.wr_data  = base + DW'(i);
      if (pattern[i]) begin
        wq.push_back({a, bus.wr_data});
        exp_mem[a] = bus.wr_data;
        a = a + 1'b1;
      end
      check_output("cmd_ready_in_write", 64'(bus.cmd_ready), 64'd0);
      tick();
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic expect_read(input logic [AW-1:0] start, input logic [LW-1:0] len);
    logic [AW-1:0] a = start;
    for (int k = 0; k <= int'(len); k++) begin
      rq.push_back({(k == int'(len)), exp_mem[a]});
      a = a + 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cycles;
    for (int i = 0; i < 16; i++) begin
      ram[i]     = 32'h1111_1111 * i;
      exp_mem[i] = 32'h1111_1111 * i;
    end
    prev_stall    = 1'b0;
    prev_data     = '0;
    rst           = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_ready  = 1'b0;
    repeat (3) tick();

    // Reset state
    check_output("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    check_output("rst_wr_ready",  64'(bus.wr_ready),  64'd0);
    check_output("rst_rd_valid",  64'(bus.rd_valid),  64'd0);
    check_output("rst_rd_data",   64'(bus.rd_data),   64'd0);
    check_output("rst_rd_last",   64'(bus.rd_last),   64'd0);
    check_output("rst_busy",      64'(busy),          64'd0);
    check_output("rst_mem_en",    64'(mem_en),        64'd0);
    check_output("rst_mem_addr",  64'(mem_addr),      64'd0);
    rst = 1'b1;
    #1;
    check_output("idle_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    tick();

    // 1: write addr 2 len 3, continuous valid
    $display("[TB] write burst addr=2 len=3");
    apply_stimulus(1'b1, 4'h2, 4'd3);
    check_output("w1_busy", 64'(busy), 64'd1);
    check_output("w1_wr_ready", 64'(bus.wr_ready), 64'd1);
    write_beats(4'h2, 16'h000F, 4, 32'hA0);
    check_output("w1_done_busy", 64'(busy), 64'd0);
    check_output("w1_writes_left", 64'(wq.size()), 64'd0);
    check_output("w1_idle_addr", 64'(mem_addr), 64'h6);
    check_output("w1_ram5", 64'(ram[5]), 64'hA3);

    // 2: read addr 2 len 3, rd_ready held high
    $display("[TB] read burst addr=2 len=3");
    bus.rd_ready = 1'b1;
    expect_read(4'h2, 4'd3);
    apply_stimulus(1'b0, 4'h2, 4'd3);
    check_output("r2_first_cycle_valid", 64'(bus.rd_valid), 64'd0);
    tick();
    check_output("r2_latency_valid", 64'(bus.rd_valid), 64'd1);
    cycles = 0;
    while (rq.size() != 0 && cycles < 20) begin
      tick();
      cycles++;
    end
    check_output("r2_beat_cycles", 64'(cycles), 64'd4);
    check_output("r2_done_valid", 64'(bus.rd_valid), 64'd0);
    check_output("r2_done_busy", 64'(busy), 64'd0);

    // 3: read with rd_ready stalls 1,0,0,...
    $display("[TB] read burst with backpressure");
    bus.rd_ready = 1'b0;
    expect_read(4'h2, 4'd3);
    apply_stimulus(1'b0, 4'h2, 4'd3);
    cycles = 0;
    while ((rq.size() != 0 || busy !== 1'b0) && cycles < 60) begin
      bus.rd_ready = (cycles % 3 == 0);
      tick();
      cycles++;
    end
    check_output("r3_reads_left", 64'(rq.size()), 64'd0);
    check_output("r3_done_busy", 64'(busy), 64'd0);

    // 4: burst crossing the top address
`ifdef MEM_BURST_BOUNDARY_CHECK_EN
    $display("[TB] boundary error command addr=E len=2");
    apply_stimulus(1'b1, 4'hE, 4'd2);
    check_output("b4_err_pulse", 64'(err), 64'd1);
    check_output("b4_busy", 64'(busy), 64'd0);
    bus.wr_valid = 1'b1;
    #1;
    check_output("b4_mem_en", 64'(mem_en), 64'd0);
    tick();
    bus.wr_valid = 1'b0;
    check_output("b4_err_clear", 64'(err), 64'd0);
    check_output("b4_busy_after", 64'(busy), 64'd0);
`else
    $display("[TB] wrapping write/read addr=E len=2");
    apply_stimulus(1'b1, 4'hE, 4'd2);
    write_beats(4'hE, 16'h0007, 3, 32'hB0);
    check_output("w4_ram0", 64'(ram[0]), 64'hB2);
    check_output("w4_ram_f", 64'(ram[15]), 64'hB1);
    bus.rd_ready = 1'b1;
    expect_read(4'hE, 4'd2);
    apply_stimulus(1'b0, 4'hE, 4'd2);
    cycles = 0;
    while ((rq.size() != 0 || busy !== 1'b0) && cycles < 20) begin
      tick();
      cycles++;
    end
    check_output("r4_reads_left", 64'(rq.size()), 64'd0);
`endif

    // 5: reset during second beat of a len=5 write
    $display("[TB] reset mid-burst");
    apply_stimulus(1'b1, 4'h8, 4'd5);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 32'hC0;
    wq.push_back({4'h8, 32'hC0});
    exp_mem[8] = 32'hC0;
    tick();
    bus.wr_data = 32'hC1;
    rst = 1'b0;
    #1;
    check_output("r5_no_write_in_reset", 64'(mem_en), 64'd0);
    check_output("r5_cmd_ready_in_reset", 64'(bus.cmd_ready), 64'd0);
    tick();
    check_output("r5_busy", 64'(busy), 64'd0);
    check_output("r5_wr_ready", 64'(bus.wr_ready), 64'd0);
    check_output("r5_rd_valid", 64'(bus.rd_valid), 64'd0);
    rst = 1'b1;
    repeat (2) tick();
    bus.wr_valid = 1'b0;
    check_output("r5_ram8_kept", 64'(ram[8]), 64'hC0);
    check_output("r5_ram9_untouched", 64'(ram[9]), 64'(exp_mem[9]));

    // 6: write with gaps in wr_valid
    $display("[TB] write burst with valid gaps");
    apply_stimulus(1'b1, 4'h3, 4'd2);
    write_beats(4'h3, 16'h0015, 5, 32'hD0);
    check_output("w6_done_busy", 64'(busy), 64'd0);
    check_output("w6_writes_left", 64'(wq.size()), 64'd0);
    check_output("w6_ram5", 64'(ram[5]), 64'hD4);

    tick();
    check_output("end_queues_empty", 64'(wq.size() + rq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
